// File: rtl/stack_driver.sv
// stack_driver: burst transmitter and self-checker for the 4-deep stack-sum
// protocol. Each accepted START produces one burst of IN_VALID/OP/IN ops
// (directed pattern or LFSR), mirrors it into a golden stack model, then waits
// for the receiver's single OUT_VALID/OUT result and checks it.
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   START, MODE       begin burst (IDLE only); 0 = LFSR ops, 1 = directed ops
//   BURST_LEN         ops per burst, clamped to MAX_BURST
//   PAT_OP, BASE_IN   directed op pattern (1 = push) and base IN value
//   SEED              LFSR seed (0 is replaced by 8'h01)
//   OP, IN, IN_VALID  op stream to the receiver
//   OUT, OUT_VALID    result from the receiver
//   BUSY, DONE, PASS  status; DONE pulses when a check completes
//   EXP_SUM           model sum at end of the last burst
//   ERR_COUNT         saturating error count, cleared only by RESET
module stack_driver #(
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 4,
    parameter int DEPTH     = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 MODE,
    input  logic [3:0]           BURST_LEN,
    input  logic [MAX_BURST-1:0] PAT_OP,
    input  logic [3:0]           BASE_IN,
    input  logic [7:0]           SEED,
    output logic                 OP,
    output logic [3:0]           IN,
    output logic                 IN_VALID,
    input  logic [5:0]           OUT,
    input  logic                 OUT_VALID,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [5:0]           EXP_SUM,
    output logic [7:0]           ERR_COUNT
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [3:0]    MAX_LEN   = 4'(MAX_BURST);
    localparam logic [AW-1:0] TOP_FULL  = AW'(DEPTH - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_DONE} state_t;

    state_t                   state;
    logic [3:0]               len;
    logic [3:0]               cnt;
    logic [WW-1:0]            wcnt;
    logic [7:0]               lfsr;
    logic                     mode_q;
    logic [MAX_BURST-1:0]     pat_q;
    logic [3:0]               base_q;
    logic [DEPTH-1:0][3:0]    mem;
    logic [AW-1:0]            top;
    logic                     empty;

    logic [7:0]               lfsr_next;
    logic [MAX_BURST-1:0]     pat_sh;
    logic                     cur_op;
    logic [3:0]               cur_in;
    logic [3:0]               len_clamped;
    logic [7:0]               seed_val;
    logic [AW-1:0]            top_inc;
    logic [AW-1:0]            top_dec;
    logic [4*DEPTH-1:0]       flat;
    logic [5:0]               sum;
    logic                     stray;
    logic                     burst_end;
    logic                     burst_err;
    logic                     burst_pass;
    logic [8:0]               err_sum;
    logic [7:0]               err_next;

    always_comb begin
        // Fibonacci x^8+x^6+x^5+x^4+1, shifting left
        lfsr_next   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        pat_sh      = pat_q >> cnt;
        cur_op      = mode_q ? pat_sh[0] : lfsr[0];
        cur_in      = mode_q ? (base_q + cnt) : lfsr[4:1];
        len_clamped = (BURST_LEN > MAX_LEN) ? MAX_LEN : BURST_LEN;
        seed_val    = (SEED == 8'h00) ? 8'h01 : SEED;
        top_inc     = top + 1'b1;
        top_dec     = top - 1'b1;

        // Popped entries are zeroed, so the sum runs over the whole array
        flat = mem;
        sum  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sum  = sum + {2'b00, flat[3:0]};
            flat = flat >> 4;
        end

        stray      = OUT_VALID && (state == S_IDLE || state == S_DRIVE);
        burst_end  = 1'b0;
        burst_err  = 1'b0;
        burst_pass = 1'b0;
        if (state == S_WAIT) begin
            if (OUT_VALID) begin
                burst_end  = 1'b1;
                burst_pass = !empty && (OUT == sum);
                burst_err  = !burst_pass;
            end else if (wcnt == WAIT_LAST) begin
                burst_end  = 1'b1;
                burst_pass = empty;
                burst_err  = !empty;
            end
        end

        err_sum  = {1'b0, ERR_COUNT} + 9'(stray) + 9'(burst_err);
        err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            OP        <= 1'b0;
            IN        <= '0;
            IN_VALID  <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            EXP_SUM   <= '0;
            ERR_COUNT <= '0;
            len       <= '0;
            cnt       <= '0;
            wcnt      <= '0;
            lfsr      <= 8'h01;
            mode_q    <= 1'b0;
            pat_q     <= '0;
            base_q    <= '0;
            mem       <= '0;
            top       <= '0;
            empty     <= 1'b1;
        end else begin
            ERR_COUNT <= err_next;
            DONE      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        BUSY <= 1'b1;
                        if (len_clamped == 4'd0) begin
                            state   <= S_DONE;
                            DONE    <= 1'b1;
                            PASS    <= 1'b1;
                            EXP_SUM <= sum;
                        end else begin
                            state  <= S_DRIVE;
                            PASS   <= 1'b0;
                            len    <= len_clamped;
                            cnt    <= '0;
                            lfsr   <= seed_val;
                            mode_q <= MODE;
                            pat_q  <= PAT_OP;
                            base_q <= BASE_IN;
                        end
                    end
                end
                S_DRIVE: begin
                    if (cnt == len) begin
                        IN_VALID <= 1'b0;
                        state    <= S_WAIT;
                        wcnt     <= '0;
                    end else begin
                        IN_VALID <= 1'b1;
                        OP       <= cur_op;
                        IN       <= cur_in;
                        cnt      <= cnt + 1'b1;
                        lfsr     <= lfsr_next;
                        if (cur_op) begin
                            if (empty) begin
                                mem[0] <= cur_in;
                                top    <= '0;
                                empty  <= 1'b0;
                            end else if (top != TOP_FULL) begin
                                mem[top_inc] <= cur_in;
                                top          <= top_inc;
                            end
                        end else if (!empty) begin
                            mem[top] <= '0;
                            if (top == '0) empty <= 1'b1;
                            else           top   <= top_dec;
                        end
                    end
                end
                S_WAIT: begin
                    if (burst_end) begin
                        state   <= S_DONE;
                        DONE    <= 1'b1;
                        PASS    <= burst_pass;
                        EXP_SUM <= sum;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_driver.sv
// Bench for stack_driver: a behavioural stack receiver answers each burst
// (combinationally from IN_VALID falling, so in wait cycle 0), directed
// vectors come from a table, and the corner cases are hand-written sequences.
module tb_stack_driver;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       MODE = 1'b0;
    logic [3:0] BURST_LEN = '0;
    logic [7:0] PAT_OP = '0;
    logic [3:0] BASE_IN = '0;
    logic [7:0] SEED = '0;
    logic       OP;
    logic [3:0] IN;
    logic       IN_VALID;
    logic [5:0] OUT;
    logic       OUT_VALID;
    logic       BUSY;
    logic       DONE;
    logic       PASS;
    logic [5:0] EXP_SUM;
    logic [7:0] ERR_COUNT;

    always #5 CLK = ~CLK;

    stack_driver #(.MAX_BURST(8), .TIMEOUT(4), .DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .MODE(MODE),
        .BURST_LEN(BURST_LEN), .PAT_OP(PAT_OP), .BASE_IN(BASE_IN), .SEED(SEED),
        .OP(OP), .IN(IN), .IN_VALID(IN_VALID), .OUT(OUT), .OUT_VALID(OUT_VALID),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .EXP_SUM(EXP_SUM),
        .ERR_COUNT(ERR_COUNT)
    );

    // Receiver model: 4-deep stack, answers with its sum once IN_VALID falls
    logic [3:0] rx_mem [4];
    int         rx_cnt;
    logic       rx_prev;
    logic [5:0] rx_sum;
    logic       rx_fault = 1'b0;
    logic       stray_ov = 1'b0;

    always @(posedge CLK) begin
        if (RESET) begin
            rx_cnt  <= 0;
            rx_prev <= 1'b0;
        end else begin
            rx_prev <= IN_VALID;
            if (IN_VALID) begin
                if (OP) begin
                    if (rx_cnt < 4) begin
                        rx_mem[rx_cnt] <= IN;
                        rx_cnt         <= rx_cnt + 1;
                    end
                end else if (rx_cnt > 0) begin
                    rx_cnt <= rx_cnt - 1;
                end
            end
        end
    end

    always_comb begin
        rx_sum = '0;
        for (int i = 0; i < 4; i++)
            if (i < rx_cnt) rx_sum = rx_sum + {2'b00, rx_mem[i]};
    end

    assign OUT_VALID = (rx_prev && !IN_VALID && rx_cnt > 0) || stray_ov;
    assign OUT       = rx_fault ? 6'd5 : rx_sum;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic run_burst(input logic mode, input logic [3:0] len, input logic [7:0] pat,
                             input logic [3:0] base, input logic [7:0] seed, input logic fault,
                             input string tag, output logic p, output logic [5:0] s);
        int         el;
        int         nv;
        int         cyc;
        logic [7:0] l;
        logic [7:0] tmp;
        logic [3:0] e_in;
        logic       e_op;
        el = (len > 4'd8) ? 8 : int'(len);
        nv = 0;
        l  = (seed == 8'h00) ? 8'h01 : seed;
        @(negedge CLK);
        MODE = mode; BURST_LEN = len; PAT_OP = pat; BASE_IN = base; SEED = seed;
        rx_fault = fault; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk({tag, " busy"}, 32'(BUSY), 1);
        if (el > 0) chk({tag, " pass_clear"}, 32'(PASS), 0);
        cyc = 0;
        while (!DONE && cyc < 40) begin
            if (IN_VALID) begin
                if (mode) begin
                    tmp  = pat >> nv;
                    e_op = tmp[0];
                    e_in = base + 4'(nv);
                end else begin
                    e_op = l[0];
                    e_in = l[4:1];
                    l    = {l[6:0], ^(l & 8'hB8)};
                end
                chk($sformatf("%s op%0d", tag, nv), 32'(OP), 32'(e_op));
                chk($sformatf("%s in%0d", tag, nv), 32'(IN), 32'(e_in));
                nv++;
            end
            @(negedge CLK);
            cyc++;
        end
        chk({tag, " done"}, 32'(DONE), 1);
        chk({tag, " valid_cycles"}, 32'(nv), 32'(el));
        p = PASS;
        s = EXP_SUM;
        @(negedge CLK);
        chk({tag, " done_one_cycle"}, 32'(DONE), 0);
        chk({tag, " idle_busy"}, 32'(BUSY), 0);
    endtask

    typedef struct {
        logic       rst;
        logic       mode;
        logic [3:0] len;
        logic [7:0] pat;
        logic [3:0] base;
        logic       fault;
        logic       exp_pass;
        logic [5:0] exp_sum;
        logic [7:0] exp_err;
        string      name;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       p;
        logic [5:0] s;
        int         nv;
        int         cyc;
        int         dcount;
        logic [7:0] sd;

        vecs[0] = '{1'b0, 1'b1, 4'd3,  8'h07, 4'd1,  1'b0, 1'b1, 6'd6,  8'd0, "push3"};
        vecs[1] = '{1'b0, 1'b1, 4'd4,  8'h00, 4'd0,  1'b0, 1'b1, 6'd0,  8'd0, "pop4_timeout"};
        vecs[2] = '{1'b0, 1'b1, 4'd6,  8'h3F, 4'd15, 1'b0, 1'b1, 6'd18, 8'd0, "push6_full"};
        vecs[3] = '{1'b0, 1'b1, 4'd0,  8'hFF, 4'd9,  1'b0, 1'b1, 6'd18, 8'd0, "len0"};
        vecs[4] = '{1'b0, 1'b1, 4'd12, 8'h00, 4'd0,  1'b0, 1'b1, 6'd0,  8'd0, "len_clamp"};
        vecs[5] = '{1'b1, 1'b1, 4'd3,  8'h07, 4'd1,  1'b1, 1'b0, 6'd6,  8'd1, "bad_rx"};

        do_reset();
        chk("rst op", 32'(OP), 0);
        chk("rst in", 32'(IN), 0);
        chk("rst in_valid", 32'(IN_VALID), 0);
        chk("rst busy", 32'(BUSY), 0);
        chk("rst done", 32'(DONE), 0);
        chk("rst pass", 32'(PASS), 0);
        chk("rst exp_sum", 32'(EXP_SUM), 0);
        chk("rst err", 32'(ERR_COUNT), 0);

        for (int k = 0; k < 6; k++) begin
            if (vecs[k].rst) do_reset();
            run_burst(vecs[k].mode, vecs[k].len, vecs[k].pat, vecs[k].base, 8'h00,
                      vecs[k].fault, vecs[k].name, p, s);
            chk({vecs[k].name, " pass"}, 32'(p), 32'(vecs[k].exp_pass));
            chk({vecs[k].name, " exp_sum"}, 32'(s), 32'(vecs[k].exp_sum));
            chk({vecs[k].name, " err"}, 32'(ERR_COUNT), 32'(vecs[k].exp_err));
        end

        // Stray response in IDLE
        rx_fault = 1'b0;
        @(negedge CLK); stray_ov = 1'b1;
        @(negedge CLK); stray_ov = 1'b0;
        @(negedge CLK);
        chk("stray_idle err", 32'(ERR_COUNT), 2);

        // Reset during the second op of a five-op burst
        @(negedge CLK);
        MODE = 1'b1; BURST_LEN = 4'd5; PAT_OP = 8'h1F; BASE_IN = 4'd2; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        nv = 0; cyc = 0;
        while (nv < 2 && cyc < 10) begin
            if (IN_VALID) nv++;
            if (nv < 2) @(negedge CLK);
            cyc++;
        end
        chk("midrst reached op2", 32'(nv), 2);
        RESET = 1'b1;
        @(negedge CLK);
        chk("midrst in_valid", 32'(IN_VALID), 0);
        chk("midrst busy", 32'(BUSY), 0);
        chk("midrst err", 32'(ERR_COUNT), 0);
        chk("midrst done", 32'(DONE), 0);
        RESET = 1'b0;
        dcount = 0;
        repeat (8) begin
            @(negedge CLK);
            if (DONE) dcount++;
        end
        chk("midrst no_done", 32'(dcount), 0);
        run_burst(1'b1, 4'd1, 8'h01, 4'd7, 8'h00, 1'b0, "post_rst", p, s);
        chk("post_rst pass", 32'(p), 1);
        chk("post_rst exp_sum", 32'(s), 7);

        // Error counter saturation
        @(negedge CLK); stray_ov = 1'b1;
        repeat (300) @(negedge CLK);
        stray_ov = 1'b0;
        @(negedge CLK);
        chk("err saturate", 32'(ERR_COUNT), 255);

        do_reset();
        chk("rst2 err", 32'(ERR_COUNT), 0);
        chk("rst2 exp_sum", 32'(EXP_SUM), 0);

        // LFSR bursts against the receiver model
        for (int k = 0; k < 100; k++) begin
            sd = (k < 50) ? 8'h00 : 8'($urandom_range(0, 255));
            run_burst(1'b0, 4'($urandom_range(1, 8)), 8'h00, 4'd0, sd, 1'b0,
                      $sformatf("lfsr%0d", k), p, s);
            chk($sformatf("lfsr%0d pass", k), 32'(p), 1);
            chk($sformatf("lfsr%0d exp_sum", k), 32'(s), 32'(rx_sum));
        end
        chk("lfsr final err", 32'(ERR_COUNT), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_driver.md
Name: stack_driver

Overview:
- Transmitter and self-checker for the 4-deep stack-sum protocol: IN_VALID/OP/IN bursts out, a single OUT_VALID/OUT[5:0] result back.
- Generates one operation burst per START, from a directed pattern or an LFSR, and drives it to the stack block.
- Keeps a golden stack model, waits for the response and checks it.
- Used in lab benches and on-board self-test; shares CLK/RESET with the stack block.

Parameters:
- MAX_BURST, 8, maximum ops per burst; width of PAT_OP.
- TIMEOUT, 4, cycles to wait for OUT_VALID after IN_VALID falls.
- DEPTH, 4, model stack depth; must match the receiver.

Ports:
- CLK  in  1  clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- START  in  1  begin a burst; sampled only in IDLE
- MODE  in  1  0 = LFSR ops, 1 = directed ops
- BURST_LEN  in  4  ops in burst, 0..MAX_BURST; larger values clamp to MAX_BURST
- PAT_OP  in  MAX_BURST  directed mode: bit i is OP of op i (1 = push, 0 = pop)
- BASE_IN  in  4  directed mode: IN of op i = BASE_IN+i mod 16
- SEED  in  8  LFSR seed, loaded on START
- OP  out  1  to receiver
- IN  out  4  to receiver
- IN_VALID  out  1  to receiver
- OUT  in  6  from receiver, sum of stack contents
- OUT_VALID  in  1  from receiver
- BUSY  out  1  high outside IDLE
- DONE  out  1  one-cycle pulse when the check completes
- PASS  out  1  result of the last burst; held until the next accepted START
- EXP_SUM  out  6  model sum at the end of the last burst
- ERR_COUNT  out  8  saturating error count; cleared only by RESET

Behaviour:
- Reset values: all outputs 0, state IDLE, model empty (top = -1), LFSR = 8'h01.
- Reset mid-burst: IN_VALID = 0 from the next edge, no DONE pulse. The receiver must be reset in the same cycle.
- All outputs are registered.
- FSM states: IDLE, DRIVE, WAIT, DONE.
- IDLE:
  - START=1 with BURST_LEN=0: go to DONE. PASS=1, EXP_SUM = current model sum, no IN_VALID.
  - START=1 with BURST_LEN>0: load the op counter, load the LFSR from SEED (SEED=0 loads 8'h01), go to DRIVE.
- DRIVE: IN_VALID=1 for exactly BURST_LEN consecutive cycles, no gaps.
  - Op i: directed mode uses OP=PAT_OP[i], IN=BASE_IN+i. LFSR mode uses OP=lfsr[0], IN=lfsr[4:1]. The LFSR (x^8+x^6+x^5+x^4+1, Fibonacci, shift left) advances once per op.
  - Model update on the same edge the op is presented:
    - push with top<DEPTH-1: store IN at top+1, increment top.
    - push when full: dropped.
    - pop with top>=0: decrement top.
    - pop when empty: no change.
  - After the last op, IN_VALID=0 and the FSM enters WAIT with wait counter = 0.
- WAIT: counts cycles from the first cycle with IN_VALID low. The receiver is required to answer in wait cycle 0 or later, up to TIMEOUT-1.
  - OUT_VALID=1 and model non-empty: PASS = (OUT == model sum); mismatch is 1 error.
  - OUT_VALID=1 and model empty: 1 error, PASS=0.
  - Counter reaches TIMEOUT with no OUT_VALID: PASS = model empty; a non-empty model is 1 error.
  - Any of these outcomes moves the FSM to DONE.
- DONE: DONE=1 for one cycle, EXP_SUM updated, return to IDLE.
- OUT_VALID seen in IDLE or DRIVE: stray response, 1 error; does not affect PASS of the burst in flight.
- Error counting:
  - ERR_COUNT increments by 1 per error and saturates at 255.
  - At most one burst error per burst, plus stray errors.
  - Only a stray error and a burst error in the same cycle count 2.
- Model sum: zero-extended 6-bit add of entries 0..top; maximum 60.
- Model persists across bursts, matching the receiver; only RESET clears it.
- START while BUSY: ignored.

Test Plan:
- After reset: MODE=1, BURST_LEN=3, PAT_OP=8'h07, BASE_IN=1 -> IN 1,2,3 with IN_VALID high 3 cycles; receiver OUT=6 in wait cycle 0 -> DONE, PASS=1, EXP_SUM=6, ERR_COUNT=0.
- Then MODE=1, BURST_LEN=4, PAT_OP=0 (four pops on 3 entries) -> model empty; no OUT_VALID; DONE after TIMEOUT=4 wait cycles, PASS=1, EXP_SUM=0.
- After reset: MODE=1, BURST_LEN=6, PAT_OP=8'h3F, BASE_IN=15 -> IN 15,0,1,2,3,4; pushes of 3 and 4 dropped; EXP_SUM=18, PASS=1.
- Faulty receiver model returning OUT=5 in scenario 1 -> PASS=0, ERR_COUNT=1; a second stray OUT_VALID in IDLE -> ERR_COUNT=2.
- RESET asserted in cycle 2 of a 5-op burst -> next edge IN_VALID=0, BUSY=0, ERR_COUNT=0, no DONE; a following 1-push burst with IN=7 -> EXP_SUM=7.
- MODE=0, SEED=0 (loads 8'h01), 100 random bursts of BURST_LEN 1..8 against the real stack block -> every DONE has PASS=1, final ERR_COUNT=0, IN sequence matches the bench LFSR model.
